multicycle_ctrl: RTL and testbench

Main sequencer for the multicycle variant of the RISC-V subset core (R-type, addi/srai, lw, sw, beq). One FSM steps each instruction through fetch, decode, execute, memory and write-back over a single shared memory port with a request/ready handshake. It drives every datapath mux, write-enable and ALUOp select, and counts retired instructions. It replaces the single-cycle opcode decoder for this datapath. ALUOp encodings match the existing ALU control: 00 add, 01 sub, 10 R-type funct, 11 I-type funct.

---
 rtl/multicycle_ctrl_pkg.sv | 30 +++
 rtl/multicycle_ctrl_outdec.sv | 82 ++++++++
 rtl/multicycle_ctrl.sv | 87 ++++++++
 tb/tb_multicycle_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle sequencer: state encoding, opcodes,
// and the ALUOp / ALUSrcB encodings also used by the ALU control.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EX_R, EX_I, EX_ADDR,
    MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  function automatic logic op_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Combinational control decode: state plus MemReady/Zero to every datapath
// select and enable. Anything a state does not drive stays 0.
module multicycle_ctrl_outdec
  import multicycle_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       mem_to_reg
);

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    unique case (state)
      FETCH: begin
        mem_req = 1'b1;
        // PC + 4 is written back in the same cycle the instruction lands
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = SRCB_FOUR;
        end
      end
      DECODE: alu_src_b = SRCB_IMM;
      EX_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      EX_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_IMM;
      end
      EX_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      WB_ALU: reg_write = 1'b1;
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 1'b1;
        pc_write  = zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer top: state register, next-state logic, retire
// counter and illegal-opcode flag; output decode lives in the sub-module.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [6:0]  Op_i,
  input  logic        Zero_i,
  input  logic        MemReady_i,
  output logic        MemReq_o,
  output logic        MemWe_o,
  output logic        IorD_o,
  output logic        IRWrite_o,
  output logic        PCWrite_o,
  output logic        PCSrc_o,
  output logic        ALUSrcA_o,
  output logic [1:0]  ALUSrcB_o,
  output logic [1:0]  ALUOp_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic        Busy_o,
  output logic        IllegalOp_o,
  output logic [31:0] InstrCnt_o,
  output state_t      State_o
);

  state_t state, state_nxt;
  logic   retire;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    unique case (state)
      IDLE:    if (start_i) state_nxt = FETCH;
      FETCH:   if (MemReady_i) state_nxt = DECODE;
      DECODE: begin
        if      (Op_i == OP_R)                    state_nxt = EX_R;
        else if (Op_i == OP_I)                    state_nxt = EX_I;
        else if (Op_i == OP_LW || Op_i == OP_SW)  state_nxt = EX_ADDR;
        else if (Op_i == OP_BEQ)                  state_nxt = BRANCH;
        else    state_nxt = stop_i ? IDLE : FETCH;
      end
      EX_R, EX_I: state_nxt = WB_ALU;
      EX_ADDR:    state_nxt = (Op_i == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:     if (MemReady_i) state_nxt = WB_MEM;
      MEM_WR:     retire = MemReady_i;
      WB_ALU, WB_MEM, BRANCH: retire = 1'b1;
      default:    state_nxt = IDLE;
    endcase
    if (retire) state_nxt = stop_i ? IDLE : FETCH;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      InstrCnt_o <= '0;
    else if (retire) InstrCnt_o <= InstrCnt_o + 32'd1;
  end

  assign Busy_o      = (state != IDLE);
  assign IllegalOp_o = (state == DECODE) && !op_legal(Op_i);
  assign State_o     = state;

  multicycle_ctrl_outdec u_outdec (
    .state      (state),
    .mem_ready  (MemReady_i),
    .zero       (Zero_i),
    .mem_req    (MemReq_o),
    .mem_we     (MemWe_o),
    .iord       (IorD_o),
    .ir_write   (IRWrite_o),
    .pc_write   (PCWrite_o),
    .pc_src     (PCSrc_o),
    .alu_src_a  (ALUSrcA_o),
    .alu_src_b  (ALUSrcB_o),
    .alu_op     (ALUOp_o),
    .reg_write  (RegWrite_o),
    .mem_to_reg (MemtoReg_o)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: inputs change and outputs are sampled
// on the falling edge, so each negedge shows the state about to be clocked.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, stop_i, Zero_i, MemReady_i;
  logic [6:0]  Op_i;
  logic        MemReq_o, MemWe_o, IorD_o, IRWrite_o, PCWrite_o, PCSrc_o;
  logic        ALUSrcA_o, RegWrite_o, MemtoReg_o, Busy_o, IllegalOp_o;
  logic [1:0]  ALUSrcB_o, ALUOp_o;
  logic [31:0] InstrCnt_o;
  state_t      State_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  multicycle_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .Op_i(Op_i), .Zero_i(Zero_i), .MemReady_i(MemReady_i),
    .MemReq_o(MemReq_o), .MemWe_o(MemWe_o), .IorD_o(IorD_o),
    .IRWrite_o(IRWrite_o), .PCWrite_o(PCWrite_o), .PCSrc_o(PCSrc_o),
    .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALUOp_o(ALUOp_o),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .Busy_o(Busy_o),
    .IllegalOp_o(IllegalOp_o), .InstrCnt_o(InstrCnt_o), .State_o(State_o)
  );

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; Zero_i = 1'b0;
    MemReady_i = 1'b0; Op_i = 7'd0;
    cyc(); cyc();
    checks++; if (State_o !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", State_o, IDLE); end
    checks++; if (InstrCnt_o !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", InstrCnt_o); end
    checks++; if ({MemReq_o, Busy_o, IllegalOp_o, PCWrite_o, RegWrite_o} !== 5'b0) begin errors++; $display("FAIL reset_outs: got %b want 00000", {MemReq_o, Busy_o, IllegalOp_o, PCWrite_o, RegWrite_o}); end
    rst_i = 1'b1;
    cyc();
  endtask

  task automatic test_rtype();
    start_i = 1'b1; Op_i = OP_R; MemReady_i = 1'b1; stop_i = 1'b0;
    cyc(); start_i = 1'b0;
    checks++; if (State_o !== FETCH) begin errors++; $display("FAIL r_fetch_state: got %0d want %0d", State_o, FETCH); end
    checks++; if ({MemReq_o, IorD_o, IRWrite_o, PCWrite_o, PCSrc_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o} !== 10'b1011000100) begin errors++; $display("FAIL r_fetch_outs: got %b want 1011000100", {MemReq_o, IorD_o, IRWrite_o, PCWrite_o, PCSrc_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o}); end
    cyc();
    checks++; if (State_o !== DECODE || ALUSrcA_o !== 1'b0 || ALUSrcB_o !== 2'b10 || ALUOp_o !== 2'b00 || Busy_o !== 1'b1) begin errors++; $display("FAIL r_decode: got st=%0d a=%b b=%b op=%b busy=%b want DECODE 0 10 00 1", State_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, Busy_o); end
    cyc();
    checks++; if (State_o !== EX_R || ALUSrcA_o !== 1'b1 || ALUSrcB_o !== 2'b00 || ALUOp_o !== 2'b10) begin errors++; $display("FAIL r_exec: got st=%0d a=%b b=%b op=%b want EX_R 1 00 10", State_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o); end
    cyc(); stop_i = 1'b1;
    checks++; if (State_o !== WB_ALU || RegWrite_o !== 1'b1 || MemtoReg_o !== 1'b0) begin errors++; $display("FAIL r_wb: got st=%0d rw=%b m2r=%b want WB_ALU 1 0", State_o, RegWrite_o, MemtoReg_o); end
    checks++; if (InstrCnt_o !== 32'd0) begin errors++; $display("FAIL r_cnt_before: got %0d want 0", InstrCnt_o); end
    cyc(); stop_i = 1'b0;
    checks++; if (State_o !== IDLE || InstrCnt_o !== 32'd1) begin errors++; $display("FAIL r_retire: got st=%0d cnt=%0d want IDLE 1", State_o, InstrCnt_o); end
  endtask

  task automatic test_lw_wait();
    int req_cycles = 0;
    int total = 0;
    start_i = 1'b1; Op_i = OP_LW; MemReady_i = 1'b1;
    cyc(); start_i = 1'b0; total++;
    cyc(); total++;
    cyc(); total++; MemReady_i = 1'b0;
    checks++; if (State_o !== EX_ADDR || ALUSrcA_o !== 1'b1 || ALUSrcB_o !== 2'b10 || ALUOp_o !== 2'b00) begin errors++; $display("FAIL lw_addr: got st=%0d a=%b b=%b op=%b want EX_ADDR 1 10 00", State_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o); end
    for (int i = 0; i < 3; i++) begin
      cyc(); total++;
      if (i == 2) MemReady_i = 1'b1;
      if (State_o == MEM_RD && MemReq_o === 1'b1 && IorD_o === 1'b1 && MemWe_o === 1'b0) req_cycles++;
    end
    checks++; if (req_cycles !== 3) begin errors++; $display("FAIL lw_req_hold: got %0d want 3", req_cycles); end
    cyc(); total++; stop_i = 1'b1;
    checks++; if (State_o !== WB_MEM || RegWrite_o !== 1'b1 || MemtoReg_o !== 1'b1 || MemReq_o !== 1'b0) begin errors++; $display("FAIL lw_wb: got st=%0d rw=%b m2r=%b req=%b want WB_MEM 1 1 0", State_o, RegWrite_o, MemtoReg_o, MemReq_o); end
    checks++; if (total !== 7) begin errors++; $display("FAIL lw_latency: got %0d want 7", total); end
    cyc(); stop_i = 1'b0;
    checks++; if (State_o !== IDLE || InstrCnt_o !== 32'd2) begin errors++; $display("FAIL lw_retire: got st=%0d cnt=%0d want IDLE 2", State_o, InstrCnt_o); end
  endtask

  task automatic test_beq();
    start_i = 1'b1; Op_i = OP_BEQ; MemReady_i = 1'b1; Zero_i = 1'b1; stop_i = 1'b0;
    cyc(); start_i = 1'b0;
    cyc();
    cyc();
    checks++; if (State_o !== BRANCH || PCWrite_o !== 1'b1 || PCSrc_o !== 1'b1 || ALUOp_o !== 2'b01 || ALUSrcA_o !== 1'b1 || ALUSrcB_o !== 2'b00) begin errors++; $display("FAIL beq_taken: got st=%0d pcw=%b src=%b op=%b a=%b b=%b want BRANCH 1 1 01 1 00", State_o, PCWrite_o, PCSrc_o, ALUOp_o, ALUSrcA_o, ALUSrcB_o); end
    cyc(); Zero_i = 1'b0;
    checks++; if (State_o !== FETCH || InstrCnt_o !== 32'd3) begin errors++; $display("FAIL beq_first_retire: got st=%0d cnt=%0d want FETCH 3", State_o, InstrCnt_o); end
    cyc();
    cyc(); stop_i = 1'b1;
    checks++; if (State_o !== BRANCH || PCWrite_o !== 1'b0 || PCSrc_o !== 1'b1) begin errors++; $display("FAIL beq_not_taken: got st=%0d pcw=%b src=%b want BRANCH 0 1", State_o, PCWrite_o, PCSrc_o); end
    cyc(); stop_i = 1'b0;
    checks++; if (State_o !== IDLE || InstrCnt_o !== 32'd4) begin errors++; $display("FAIL beq_second_retire: got st=%0d cnt=%0d want IDLE 4", State_o, InstrCnt_o); end
  endtask

  task automatic test_illegal();
    start_i = 1'b1; Op_i = 7'b1111111; MemReady_i = 1'b1; stop_i = 1'b0;
    cyc(); start_i = 1'b0;
    checks++; if (IllegalOp_o !== 1'b0) begin errors++; $display("FAIL ill_fetch_quiet: got %b want 0", IllegalOp_o); end
    cyc();
    checks++; if (State_o !== DECODE || IllegalOp_o !== 1'b1) begin errors++; $display("FAIL ill_pulse: got st=%0d ill=%b want DECODE 1", State_o, IllegalOp_o); end
    cyc();
    checks++; if (State_o !== FETCH || IllegalOp_o !== 1'b0 || InstrCnt_o !== 32'd4) begin errors++; $display("FAIL ill_after: got st=%0d ill=%b cnt=%0d want FETCH 0 4", State_o, IllegalOp_o, InstrCnt_o); end
    Op_i = OP_BEQ; stop_i = 1'b1;
    cyc();
    cyc();
    cyc(); stop_i = 1'b0;
    checks++; if (State_o !== IDLE || InstrCnt_o !== 32'd5) begin errors++; $display("FAIL ill_recover: got st=%0d cnt=%0d want IDLE 5", State_o, InstrCnt_o); end
  endtask

  task automatic test_stop_sw();
    int stray = 0;
    start_i = 1'b1; stop_i = 1'b1; Op_i = OP_SW; MemReady_i = 1'b1;
    cyc(); start_i = 1'b0;
    cyc();
    cyc();
    cyc();
    checks++; if (State_o !== MEM_WR || MemReq_o !== 1'b1 || MemWe_o !== 1'b1 || IorD_o !== 1'b1) begin errors++; $display("FAIL sw_memwr: got st=%0d req=%b we=%b iord=%b want MEM_WR 1 1 1", State_o, MemReq_o, MemWe_o, IorD_o); end
    cyc();
    checks++; if (State_o !== IDLE || Busy_o !== 1'b0 || InstrCnt_o !== 32'd6) begin errors++; $display("FAIL sw_stop: got st=%0d busy=%b cnt=%0d want IDLE 0 6", State_o, Busy_o, InstrCnt_o); end
    stop_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (MemReq_o !== 1'b0 || State_o !== IDLE) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL sw_idle_quiet: got %0d active cycles want 0", stray); end
  endtask

  task automatic test_reset_mid_write();
    start_i = 1'b1; Op_i = OP_SW; MemReady_i = 1'b1;
    cyc(); start_i = 1'b0;
    cyc(); MemReady_i = 1'b0;
    cyc();
    cyc();
    cyc();
    checks++; if (State_o !== MEM_WR || MemReq_o !== 1'b1 || MemWe_o !== 1'b1) begin errors++; $display("FAIL rst_wait_hold: got st=%0d req=%b we=%b want MEM_WR 1 1", State_o, MemReq_o, MemWe_o); end
    #2 rst_i = 1'b0;
    #1;
    checks++; if (MemReq_o !== 1'b0 || MemWe_o !== 1'b0 || State_o !== IDLE || InstrCnt_o !== 32'd0 || Busy_o !== 1'b0) begin errors++; $display("FAIL rst_async: got req=%b we=%b st=%0d cnt=%0d busy=%b want 0 0 IDLE 0 0", MemReq_o, MemWe_o, State_o, InstrCnt_o, Busy_o); end
    cyc(); rst_i = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_stop_sw();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
